// File: rtl/seq_comparator.sv
// Multi-cycle magnitude comparator: scans operands MSB-chunk first, CHUNK bits per cycle.
// Optional min/max outputs are enabled by defining SEQ_COMPARATOR_MINMAX_EN.
module seq_comparator #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               comp_in0,
  input  logic [WIDTH-1:0]               comp_in1,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           SLT,
  output logic                           SLTU,
  output logic                           EQ,
  output logic [$clog2(WIDTH/CHUNK):0]   busy_cycles
`ifdef SEQ_COMPARATOR_MINMAX_EN
  ,
  input  logic                           min_signed,
  output logic [WIDTH-1:0]               min_out,
  output logic [WIDTH-1:0]               max_out
`endif
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned BW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [BW-1:0]     busy_q, busy_d;
  logic              slt_q, slt_d;
  logic              sltu_q, sltu_d;
  logic              eq_q, eq_d;

  logic [CHUNK-1:0]  slice_a;
  logic [CHUNK-1:0]  slice_b;
  logic              slices_differ;
  logic              sltu_hit;
  logic              slt_hit;

`ifdef SEQ_COMPARATOR_MINMAX_EN
  logic              ms_q, ms_d;
  logic [WIDTH-1:0]  min_q, min_d;
  logic [WIDTH-1:0]  max_q, max_d;
  logic              lt_sel;
`endif

  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx_q == IW'(i)) begin
        slice_a = a_q[i*CHUNK +: CHUNK];
        slice_b = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  // Sign bits only matter once a difference is found; equal operands have equal signs.
  assign slices_differ = (slice_a != slice_b);
  assign sltu_hit      = (slice_a < slice_b);
  assign slt_hit       = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? a_q[WIDTH-1] : sltu_hit;

`ifdef SEQ_COMPARATOR_MINMAX_EN
  assign lt_sel = ms_q ? slt_hit : sltu_hit;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    slt_d   = slt_q;
    sltu_d  = sltu_q;
    eq_d    = eq_q;
`ifdef SEQ_COMPARATOR_MINMAX_EN
    ms_d    = ms_q;
    min_d   = min_q;
    max_d   = max_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = comp_in0;
          b_d     = comp_in1;
          idx_d   = IW'(N - 1);
          busy_d  = '0;
          slt_d   = 1'b0;
          sltu_d  = 1'b0;
          eq_d    = 1'b0;
`ifdef SEQ_COMPARATOR_MINMAX_EN
          ms_d    = min_signed;
`endif
          state_d = SCAN;
        end
      end
      SCAN: begin
        busy_d = busy_q + BW'(1);
        if (slices_differ || (idx_q == '0)) begin
          sltu_d  = sltu_hit;
          slt_d   = slt_hit;
          eq_d    = ~slices_differ;
`ifdef SEQ_COMPARATOR_MINMAX_EN
          // Equal operands take the not-less path, leaving both outputs equal to A.
          min_d   = lt_sel ? a_q : b_q;
          max_d   = lt_sel ? b_q : a_q;
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      busy_q  <= '0;
      slt_q   <= 1'b0;
      sltu_q  <= 1'b0;
      eq_q    <= 1'b0;
`ifdef SEQ_COMPARATOR_MINMAX_EN
      ms_q    <= 1'b0;
      min_q   <= '0;
      max_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      slt_q   <= slt_d;
      sltu_q  <= sltu_d;
      eq_q    <= eq_d;
`ifdef SEQ_COMPARATOR_MINMAX_EN
      ms_q    <= ms_d;
      min_q   <= min_d;
      max_q   <= max_d;
`endif
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign SLT         = slt_q;
  assign SLTU        = sltu_q;
  assign EQ          = eq_q;
  assign busy_cycles = busy_q;
`ifdef SEQ_COMPARATOR_MINMAX_EN
  assign min_out     = min_q;
  assign max_out     = max_q;
`endif

endmodule

// File: doc/seq_comparator.md
SEQ_COMPARATOR -- requirements
Module: seq_comparator

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; SHALL be a multiple of CHUNK and at least CHUNK.
REQ-002 Parameter CHUNK, default 8: bits compared per cycle; SHALL be at least 1.
REQ-003 Port clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port in_valid  input  1  operand pair offered.
REQ-006 Port in_ready  output  1  block able to accept operands.
REQ-007 Port comp_in0  input  WIDTH  operand A.
REQ-008 Port comp_in1  input  WIDTH  operand B.
REQ-009 Port out_valid  output  1  result available.
REQ-010 Port out_ready  input  1  consumer accepts result.
REQ-011 Port SLT  output  1  A < B, two's-complement signed.
REQ-012 Port SLTU  output  1  A < B, unsigned.
REQ-013 Port EQ  output  1  A == B.
REQ-014 Port busy_cycles  output  clog2(WIDTH/CHUNK)+1  SCAN cycles spent on the current result.

Function
REQ-015 The FSM SHALL have three states, IDLE, SCAN and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-016 IDLE with in_valid=1 SHALL register both operands, set the chunk index to the top chunk (N-1, where N=WIDTH/CHUNK), clear busy_cycles, and go to SCAN.
REQ-017 Each SCAN cycle SHALL compare the current CHUNK-bit slices unsigned and increment busy_cycles.
- Slices differ: SLTU = (sliceA < sliceB), EQ = 0, go to DONE.
- Slices equal at index 0: SLTU = 0, EQ = 1, go to DONE.
- Otherwise: decrement the index and stay in SCAN.
REQ-018 SCAN latency SHALL be (N - k) cycles, where k is the index of the most significant differing chunk; it SHALL be N cycles when the operands are equal.
REQ-019 SLT SHALL equal comp_in0[WIDTH-1] when the operand sign bits differ; otherwise SLT SHALL equal SLTU.
REQ-020 SLT, SLTU, EQ and busy_cycles SHALL be registered and held stable throughout DONE.
REQ-021 DONE with out_ready=1 SHALL go to IDLE; the next operands SHALL be accepted no earlier than the following cycle.
REQ-022 in_valid SHALL be ignored outside IDLE, and operands SHALL NOT change during SCAN.
REQ-023 out_ready SHALL be ignored outside DONE.
REQ-024 CHUNK == WIDTH SHALL give a 1-cycle SCAN for every operand pair.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, in_ready=1 (from the cycle after release), out_valid=0, and SLT=SLTU=EQ=0, busy_cycles=0, with operand registers cleared.
REQ-026 Reset asserted during SCAN or DONE SHALL abort the operation with no result delivered.

Configuration
REQ-027 Macro SEQ_COMPARATOR_MINMAX_EN defined: the block SHALL add a WIDTH-bit min_out and a WIDTH-bit max_out, plus a 1-bit input min_signed.
- The value of min_signed SHALL be captured with the operands.
- In DONE, min_out/max_out SHALL hold the smaller/larger operand per SLT (min_signed=1) or SLTU (min_signed=0).
- For equal operands, both SHALL equal comp_in0.
- Both SHALL reset to 0.
REQ-028 Macro SEQ_COMPARATOR_MINMAX_EN undefined: the ports min_out, max_out and min_signed and all associated logic SHALL be absent.

Verification (WIDTH=32, CHUNK=8)
REQ-029 A=0x00000005, B=0x00000007 -> 4 SCAN cycles; SLT=1, SLTU=1, EQ=0, busy_cycles=4.
REQ-030 A=0xFFFFFFFF, B=0x00000001 -> 1 SCAN cycle; SLT=1, SLTU=0, EQ=0, busy_cycles=1.
REQ-031 A=B=0x80000000 -> 4 SCAN cycles; SLT=0, SLTU=0, EQ=1.
REQ-032 out_ready held 0 for 5 cycles in DONE -> out_valid and results stable for those cycles, in_ready=0, and new in_valid ignored.
REQ-033 rst_n pulsed low during SCAN, second cycle -> out_valid never asserts; all outputs 0; in_ready=1 after release.
REQ-034 With MINMAX_EN: A=0xFFFFFFFE, B=0x00000003, min_signed=1 -> min_out=0xFFFFFFFE; with min_signed=0 -> min_out=0x00000003.
